// File: rtl/hazard_ctrl_20.sv
// Hazard controller for the 5-stage core: EX forwarding selects, load-use stall,
// branch flush, and data-memory wait-state freeze with a sticky timeout error.
// Latency: control outputs are combinational; FSM and counters update on clk.
// Backpressure: mem_ready low freezes F..M and bubbles W; ERR holds the freeze until rst.
// Optional build macro: HAZARD_PERF_EN adds saturating stall/flush performance counters.
`timescale 1ns/1ps
module hazard_ctrl_20 #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RS1_E,
  input  logic [4:0]       RS2_E,
  input  logic [4:0]       RD_E,
  input  logic [4:0]       RD_M,
  input  logic [4:0]       RD_W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemAccessM,
  input  logic             mem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_err,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [1:0] S_RUN  = 2'b00;
  localparam logic [1:0] S_WAIT = 2'b01;
  localparam logic [1:0] S_ERR  = 2'b10;
  // Last wait count before giving up on the memory.
  localparam logic [7:0] TERM   = 8'(MEM_TIMEOUT - 1);

  logic [1:0] state, state_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       err_q, err_nxt;
  logic       memstall, ld_use;
  logic       sf, sd, se, sm, fd, fe, fw;
  logic [1:0] fa, fb;

  // Forwarding: memory-stage result wins over writeback; x0 never forwards.
  always_comb begin
    fa = 2'b00;
    fb = 2'b00;
    if (RegWriteM && RD_M != 5'd0 && RD_M == RS1_E)      fa = 2'b10;
    else if (RegWriteW && RD_W != 5'd0 && RD_W == RS1_E) fa = 2'b01;
    if (RegWriteM && RD_M != 5'd0 && RD_M == RS2_E)      fb = 2'b10;
    else if (RegWriteW && RD_W != 5'd0 && RD_W == RS2_E) fb = 2'b01;
  end

  assign memstall = (state == S_RUN  && MemAccessM && !mem_ready) ||
                    (state == S_WAIT && !mem_ready) ||
                    (state == S_ERR);
  assign ld_use   = ResultSrcE && RD_E != 5'd0 && (RD_E == RS1_D || RD_E == RS2_D);

  // Stall/flush priority: memory freeze, then taken branch, then load-use bubble.
  // A branch pending in the frozen E register simply acts once the freeze lifts.
  always_comb begin
    {sf, sd, se, sm, fd, fe, fw} = 7'b0;
    if (memstall) begin
      {sf, sd, se, sm, fw} = 5'b11111;
    end else if (PCSrcE) begin
      fd = 1'b1;
      fe = 1'b1;
    end else if (ld_use) begin
      sf = 1'b1;
      sd = 1'b1;
      fe = 1'b1;
    end
  end

  // Next-state and wait-counter logic; counter saturates at the terminal count.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    err_nxt   = err_q;
    case (state)
      S_RUN: begin
        if (memstall) begin
          state_nxt = S_WAIT;
          wcnt_nxt  = 8'd1;
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          state_nxt = S_RUN;
          wcnt_nxt  = 8'd0;
        end else if (wcnt >= TERM) begin
          state_nxt = S_ERR;
          err_nxt   = 1'b1;
        end else begin
          wcnt_nxt  = wcnt + 8'd1;
        end
      end
      S_ERR: begin
        err_nxt   = 1'b1;
      end
      default: begin
        state_nxt = S_RUN;
        wcnt_nxt  = 8'd0;
      end
    endcase
  end

  // FSM registers; ERR is only left through reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_RUN;
      wcnt  <= 8'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      err_q <= err_nxt;
    end
  end

  // Every output is forced low while reset is held, including the combinational selects.
  assign StallF    = rst & sf;
  assign StallD    = rst & sd;
  assign StallE    = rst & se;
  assign StallM    = rst & sm;
  assign FlushD    = rst & fd;
  assign FlushE    = rst & fe;
  assign FlushW    = rst & fw;
  assign ForwardAE = rst ? fa : 2'b00;
  assign ForwardBE = rst ? fb : 2'b00;
  assign mem_err   = rst & err_q;
  assign state_o   = rst ? state : S_RUN;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  // Saturating counts of fetch-stall cycles and execute-flush cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (StallF && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
      if (FlushE && flush_q != '1) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_20.sv
// Bench for hazard_ctrl_20: directed stimulus, expected output vectors queued
// per cycle and compared at the falling edge; counters checked against tallies.
`timescale 1ns/1ps
module tb_hazard_ctrl_20;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
  logic        RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemAccessM, mem_ready;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
  logic [1:0]  ForwardAE, ForwardBE, state_o;
  logic [15:0] stall_cycles, flush_count;

  always #5 clk = ~clk;

  hazard_ctrl_20 #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
    .RD_M(RD_M), .RD_W(RD_W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemAccessM(MemAccessM),
    .mem_ready(mem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_err(mem_err), .state_o(state_o),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // ctl bit order: StallF StallD StallE StallM FlushD FlushE FlushW
  typedef struct packed {
    logic [6:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       err;
    logic [1:0] st;
  } exp_t;

  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] LDU  = 7'b1100010;
  localparam logic [6:0] BR   = 7'b0000110;
  localparam logic [6:0] MEM  = 7'b1111001;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [6:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                              input logic err, input logic [1:0] st);
    exp_t e;
    e.ctl = ctl; e.fa = fa; e.fb = fb; e.err = err; e.st = st;
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    o.fa  = ForwardAE;
    o.fb  = ForwardBE;
    o.err = mem_err;
    o.st  = state_o;
    return o;
  endfunction

  // One clock: queue the expectation for the inputs just driven, compare mid-cycle,
  // then move to just after the next rising edge.
  task automatic step(input string tag, input exp_t e);
    exp_t want;
    sb_q.push_back(e);
    if (rst) begin
      if (e.ctl[6]) exp_stall++;
      if (e.ctl[1]) exp_flush++;
    end
    @(negedge clk);
    want = sb_q.pop_front();
    chk(tag, 32'(observe()), 32'(want));
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    RS1_D = 0; RS2_D = 0; RS1_E = 0; RS2_E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
    MemAccessM = 0; mem_ready = 1;
  endtask

  task automatic chk_counters(input string tag);
`ifdef HAZARD_PERF_EN
    chk({tag, "_stall"}, 32'(stall_cycles), 32'(exp_stall));
    chk({tag, "_flush"}, 32'(flush_count),  32'(exp_flush));
`else
    chk({tag, "_stall"}, 32'(stall_cycles), 32'd0);
    chk({tag, "_flush"}, 32'(flush_count),  32'd0);
`endif
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    // Forwarding condition present while in reset must still read 0.
    RegWriteM = 1; RD_M = 3; RS1_E = 3; MemAccessM = 1; mem_ready = 0;
    step("reset_outputs", mk(NONE, 2'b00, 2'b00, 0, 2'b00));
    chk_counters("reset_cnt");
    rst = 1'b1;
    clear_inputs();

    // Forwarding
    RegWriteM = 1; RD_M = 3; RS1_E = 3; RegWriteW = 1; RD_W = 3;
    step("fwd_m_prio", mk(NONE, 2'b10, 2'b00, 0, 2'b00));
    RegWriteM = 0;
    step("fwd_w", mk(NONE, 2'b01, 2'b00, 0, 2'b00));
    RegWriteM = 1; RD_M = 0; RD_W = 0; RS1_E = 0;
    step("fwd_x0", mk(NONE, 2'b00, 2'b00, 0, 2'b00));
    RegWriteM = 0; RD_W = 7; RS2_E = 7; RS1_E = 2;
    step("fwd_b_w", mk(NONE, 2'b00, 2'b01, 0, 2'b00));
    clear_inputs();

    // Load-use bubbles
    ResultSrcE = 1; RD_E = 5; RS2_D = 5;
    step("ldu_rs2", mk(LDU, 2'b00, 2'b00, 0, 2'b00));
    ResultSrcE = 0;
    step("ldu_after", mk(NONE, 2'b00, 2'b00, 0, 2'b00));
    ResultSrcE = 1; RD_E = 0; RS2_D = 0;
    step("ldu_x0", mk(NONE, 2'b00, 2'b00, 0, 2'b00));
    RD_E = 9; RS1_D = 9;
    step("ldu_rs1", mk(LDU, 2'b00, 2'b00, 0, 2'b00));
    clear_inputs();
    step("idle", mk(NONE, 2'b00, 2'b00, 0, 2'b00));
    ResultSrcE = 1; RD_E = 5; RS2_D = 5;
    step("ldu_3", mk(LDU, 2'b00, 2'b00, 0, 2'b00));

    // Branch, including over a load-use hazard
    PCSrcE = 1; RS1_D = 5;
    step("br_over_ldu", mk(BR, 2'b00, 2'b00, 0, 2'b00));
    clear_inputs();
    PCSrcE = 1;
    step("br_plain", mk(BR, 2'b00, 2'b00, 0, 2'b00));
    clear_inputs();
    step("idle2", mk(NONE, 2'b00, 2'b00, 0, 2'b00));
    chk_counters("perf_ldu_br");

    // Memory wait: three not-ready cycles then ready; branch held until release
    MemAccessM = 1; mem_ready = 0;
    step("wait_c0", mk(MEM, 2'b00, 2'b00, 0, 2'b00));
    PCSrcE = 1;
    step("wait_c1", mk(MEM, 2'b00, 2'b00, 0, 2'b01));
    step("wait_c2", mk(MEM, 2'b00, 2'b00, 0, 2'b01));
    mem_ready = 1;
    step("wait_rel", mk(BR, 2'b00, 2'b00, 0, 2'b01));
    clear_inputs();
    step("wait_run", mk(NONE, 2'b00, 2'b00, 0, 2'b00));
    chk_counters("perf_wait");

    // Timeout into sticky ERR
    MemAccessM = 1; mem_ready = 0;
    step("to_c0", mk(MEM, 2'b00, 2'b00, 0, 2'b00));
    step("to_c1", mk(MEM, 2'b00, 2'b00, 0, 2'b01));
    step("to_c2", mk(MEM, 2'b00, 2'b00, 0, 2'b01));
    step("to_c3", mk(MEM, 2'b00, 2'b00, 0, 2'b01));
    step("to_err", mk(MEM, 2'b00, 2'b00, 1, 2'b10));
    MemAccessM = 0; mem_ready = 1; RegWriteM = 1; RD_M = 3; RS1_E = 3;
    step("err_sticky", mk(MEM, 2'b10, 2'b00, 1, 2'b10));
    step("err_hold", mk(MEM, 2'b10, 2'b00, 1, 2'b10));
    chk_counters("perf_err");

    // Asynchronous reset away from the clock edge
    #2 rst = 1'b0;
    #1;
    chk("arst_outputs", 32'(observe()), 32'(mk(NONE, 2'b00, 2'b00, 0, 2'b00)));
    exp_stall = 0;
    exp_flush = 0;
    chk_counters("arst_cnt");
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_inputs();
    step("post_arst", mk(NONE, 2'b00, 2'b00, 0, 2'b00));

    // Reset asserted while in WAIT
    MemAccessM = 1; mem_ready = 0;
    step("mw_c0", mk(MEM, 2'b00, 2'b00, 0, 2'b00));
    step("mw_c1", mk(MEM, 2'b00, 2'b00, 0, 2'b01));
    #3 rst = 1'b0;
    #1;
    chk("mw_arst", 32'(observe()), 32'(mk(NONE, 2'b00, 2'b00, 0, 2'b00)));
    exp_stall = 0;
    exp_flush = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_inputs();
    step("mw_run", mk(NONE, 2'b00, 2'b00, 0, 2'b00));
    chk_counters("final_cnt");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
